// File: rtl/apb_arbiter.sv
// Two-requester round-robin APB master sharing one slave between two clients.
// Define APB_TIMEOUT_EN to build the ACCESS-phase timeout abort (TIMEOUT_CYCLES).
module apb_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        wr0_i,
  input  logic        wr1_i,
  input  logic [9:0]  addr0_i,
  input  logic [9:0]  addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        done0_o,
  output logic        done1_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [9:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   last_gnt_r;
  logic   winner_s;
  logic   grant_s;
  logic   timeout_s;

`ifdef APB_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;

  // Abort when this stalled ACCESS cycle brings the count up to the limit
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r == ST_ACCESS) && !pready_i &&
        ((int'(tmo_cnt_r) + 1) >= TIMEOUT_CYCLES)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Stall counter: cleared on grant, saturating increment while pready is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_r <= 8'd0;
    end else if (grant_s) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == ST_ACCESS) && !pready_i && (tmo_cnt_r != 8'hFF)) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  // No counter in this build; the limit has no effect
  assign timeout_s = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Round-robin pick and next-state decode
  always_comb begin
    winner_s     = 1'b0;
    grant_s      = 1'b0;
    next_state_s = state_r;
    if (req0_i && req1_i) begin
      winner_s = ~last_gnt_r;
    end else if (req1_i) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          next_state_s = ST_SETUP;
          grant_s      = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP:  next_state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i || timeout_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // State, registered APB phase outputs, latched transfer and completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      last_gnt_r <= 1'b1;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      pwrite_o   <= 1'b0;
      paddr_o    <= 10'd0;
      pwdata_o   <= 32'd0;
      rdata_o    <= 32'd0;
      done0_o    <= 1'b0;
      done1_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      psel_o    <= (next_state_s == ST_SETUP) || (next_state_s == ST_ACCESS);
      penable_o <= (next_state_s == ST_ACCESS);
      done0_o   <= (next_state_s == ST_DONE) && !last_gnt_r;
      done1_o   <= (next_state_s == ST_DONE) && last_gnt_r;
      err_o     <= (next_state_s == ST_DONE) && timeout_s;
      if (grant_s) begin
        last_gnt_r <= winner_s;
        pwrite_o   <= winner_s ? wr1_i    : wr0_i;
        paddr_o    <= winner_s ? addr1_i  : addr0_i;
        pwdata_o   <= winner_s ? wdata1_i : wdata0_i;
      end else begin
        last_gnt_r <= last_gnt_r;
        pwrite_o   <= pwrite_o;
        paddr_o    <= paddr_o;
        pwdata_o   <= pwdata_o;
      end
      // pready beats a same-cycle timeout; writes and aborts return zero
      if ((state_r == ST_ACCESS) && pready_i) begin
        rdata_o <= pwrite_o ? 32'd0 : prdata_i;
      end else if (timeout_s) begin
        rdata_o <= 32'd0;
      end else begin
        rdata_o <= rdata_o;
      end
    end
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-requester APB master that shares one APB slave (the 10-bit-address, 32-bit-data register/memory slave) between two internal clients. Each request is arbitrated round-robin, converted into a standard APB SETUP/ACCESS transfer, and completed with a one-cycle done pulse carrying read data. The block sits between the client logic and the slave's `psel_i`/`penable_i`/`paddr_i`/`pwrite_i`/`pwdata_i`/`prdata_o`/`pready_o` pins.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: ACCESS-phase cycles with `pready_i` low before abort. Used only when `APB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req0_i` / `req1_i`  in  1  transfer request. Held high until the matching done pulse.
- `wr0_i` / `wr1_i`  in  1  1 = write, 0 = read.
- `addr0_i` / `addr1_i`  in  10  transfer address.
- `wdata0_i` / `wdata1_i`  in  32  write data.
- `done0_o` / `done1_o`  out  1  one-cycle completion pulse for the requester.
- `rdata_o`  out  32  read data. Valid while a done pulse is high for a read.
- `err_o`  out  1  timeout abort flag. Valid with the done pulse.
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB control.
- `paddr_o`  out  10  APB address.
- `pwdata_o`  out  32  APB write data.
- `prdata_i`  in  32  APB read data.
- `pready_i`  in  1  APB ready.

## Operation
- FSM states and transitions:
  - IDLE → SETUP when either request is high.
  - SETUP → ACCESS unconditionally.
  - ACCESS → DONE when `pready_i` = 1, or on timeout.
  - DONE → IDLE unconditionally.
- Arbitration happens only in IDLE.
  - If one request is high, that requester is granted.
  - If both are high, the requester not granted last time wins.
  - `last_gnt` resets to 1, so requester 0 wins the first tie.
- On IDLE→SETUP, the winner's `wr`/`addr`/`wdata` are latched into `pwrite_o`/`paddr_o`/`pwdata_o`.
  - These hold stable through SETUP and ACCESS, and hold through DONE.
  - Later changes on the requester inputs are ignored.
- Phase outputs:
  - SETUP: `psel_o` = 1, `penable_o` = 0.
  - ACCESS: `psel_o` = 1, `penable_o` = 1.
  - IDLE and DONE: both 0.
- On the ACCESS cycle where `pready_i` = 1:
  - For a read, `prdata_i` is registered into `rdata_o`.
  - For a write, `rdata_o` is loaded with 0.
- DONE (one cycle):
  - The granted requester's `doneN_o` = 1.
  - `rdata_o` and `err_o` are valid.
- The requester must drop `req` on the edge that ends DONE. Requests are ignored during DONE, so a held request is not re-granted until the IDLE cycle.
- Reset values (synchronous, `reset` = 0): every output 0, state IDLE, `last_gnt` = 1, timeout counter 0.
- Reset asserted mid-transfer: next cycle is IDLE with `psel_o` = 0. No done pulse is issued for the aborted transfer.

## Timing
- Minimum transfer is 4 cycles: IDLE(arbitrate), SETUP, ACCESS(`pready_i` = 1), DONE.
  - Done appears 3 cycles after the IDLE cycle in which `req` was sampled.
- Each `pready_i` = 0 cycle in ACCESS adds one cycle.
- Back-to-back transfers are separated by one IDLE cycle, giving a 4-cycle minimum per transfer.
- `doneN_o` pulse width is exactly 1 cycle. `done0_o` and `done1_o` are never high together.
- Timeout counter:
  - 8-bit; `TIMEOUT_CYCLES` ≤ 255.
  - Cleared on SETUP entry.
  - Increments each ACCESS cycle with `pready_i` = 0.
  - Saturates, never wraps.
- If `pready_i` = 1 on the same cycle the count reaches the limit, `pready_i` wins: normal completion, `err_o` = 0.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - When the counter reaches `TIMEOUT_CYCLES`, ACCESS → DONE with `err_o` = 1 and `rdata_o` = 0.
  - The slave sees `psel_o`/`penable_o` drop on DONE.
- `APB_TIMEOUT_EN` undefined:
  - No counter is built. ACCESS waits on `pready_i` indefinitely.
  - `err_o` is tied to 0.

## Test plan
- Single write: requester 0 writes addr 0x055, data 0xDEADBEEF, `pready_i` = 1 immediately.
  - APB SETUP then ACCESS carry exactly those values.
  - `done0_o` pulses 3 cycles after the request; `err_o` = 0.
- Single read with wait states: requester 1 reads addr 0x3FF, slave holds `pready_i` = 0 for 2 cycles and returns 0x12345678.
  - ACCESS lasts 3 cycles.
  - `done1_o` = 1 with `rdata_o` = 0x12345678.
- Simultaneous requests: both requests rise together out of reset.
  - Requester 0 is served first, then requester 1.
  - Both requests held continuously give strict alternation 0,1,0,1 over 4 transfers.
- Input change mid-transfer: requester 0 changes `addr0_i` during ACCESS.
  - `paddr_o` keeps the latched address.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 16): `pready_i` stuck at 0.
  - DONE after 16 ACCESS cycles with `err_o` = 1 and `rdata_o` = 0.
  - Without the macro, no done pulse occurs after 100 cycles.
- Reset during ACCESS: drive `reset` = 0 for 1 cycle.
  - Next cycle all outputs are 0 and no done pulse is issued.
  - On a subsequent tie, requester 0 is granted.
